// File: rtl/pwm_gpio_pkg.sv
// Shared encodings for the multi-channel PWM/GPIO peripheral: modes, register
// offsets and bit positions inside CTRL and STATUS.
package pwm_gpio_pkg;

    typedef enum logic [1:0] {
        ModeIn     = 2'b00,
        ModeStatic = 2'b01,
        ModePdm    = 2'b10,
        ModePwm    = 2'b11
    } mode_e;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegDuty   = 2'd1;
    localparam logic [1:0] RegPeriod = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    localparam int unsigned CtrlModeLo = 0;
    localparam int unsigned CtrlModeHi = 1;
    localparam int unsigned CtrlInv    = 2;
    localparam int unsigned CtrlLevel  = 3;
    localparam int unsigned CtrlOe     = 4;
    localparam int unsigned CtrlW      = 5;

    localparam int unsigned StatPin  = 0;
    localparam int unsigned StatRise = 1;
    localparam int unsigned StatFall = 2;
    localparam int unsigned StatW    = 3;

endpackage

// File: rtl/pwm_channel.sv
// One GPIO/PWM channel: config registers, double-buffered duty/period,
// PWM counter, PDM accumulator, input synchroniser with sticky edge capture.
module pwm_channel
    import pwm_gpio_pkg::*;
#(
    parameter int unsigned PWM_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wen_ctrl,
    input  logic               i_wen_duty,
    input  logic               i_wen_period,
    input  logic [7:0]         i_wdata,
    input  logic               i_stat_clr,
    input  logic               i_pin,
    output logic [CtrlW-1:0]   o_ctrl,
    output logic [PWM_W-1:0]   o_duty,
    output logic [PWM_W-1:0]   o_period,
    output logic [StatW-1:0]   o_status,
    output logic               o_pin_out,
    output logic               o_pin_oe
);

    logic [CtrlW-1:0] r_ctrl;
    logic [PWM_W-1:0] r_duty_sh, r_period_sh, r_duty_act, r_period_act;
    logic [PWM_W-1:0] r_cnt, w_cnt_nxt;
    logic [PWM_W:0]   r_acc, w_acc_nxt;
    logic             r_sync1, r_sync2, r_prev, r_rise, r_fall;
    logic             r_out, r_oe;
    mode_e            w_mode;
    logic             w_wrap, w_copy, w_raw, w_mode_chg, w_out, w_oe;

    always_comb begin
        w_mode     = mode_e'(r_ctrl[CtrlModeHi:CtrlModeLo]);
        w_wrap     = (r_cnt >= r_period_act);
        w_mode_chg = i_wen_ctrl && (i_wdata[CtrlModeHi:CtrlModeLo] != r_ctrl[CtrlModeHi:CtrlModeLo]);
        w_cnt_nxt  = r_cnt;
        w_acc_nxt  = r_acc;
        w_copy     = 1'b1;
        w_raw      = 1'b0;
        unique case (w_mode)
            ModeIn:     w_raw = 1'b0;
            ModeStatic: w_raw = r_ctrl[CtrlLevel];
            ModePdm: begin
                w_acc_nxt = {1'b0, r_acc[PWM_W-1:0]} + {1'b0, r_duty_act};
                w_raw     = r_acc[PWM_W];
            end
            ModePwm: begin
                w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
                w_copy    = w_wrap;
                w_raw     = (r_cnt < r_duty_act);
            end
        endcase
        // Counters restart from zero whenever the mode field actually changes.
        if (w_mode_chg) begin
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
        end
        w_out = (w_mode == ModeIn) ? 1'b0 : (w_raw ^ r_ctrl[CtrlInv]);
        w_oe  = (w_mode != ModeIn) && r_ctrl[CtrlOe];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl       <= '0;
            r_duty_sh    <= '0;
            r_period_sh  <= '0;
            r_duty_act   <= '0;
            r_period_act <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_prev       <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_out        <= 1'b0;
            r_oe         <= 1'b0;
        end else begin
            if (i_wen_ctrl)   r_ctrl      <= i_wdata[CtrlW-1:0];
            if (i_wen_duty)   r_duty_sh   <= i_wdata[PWM_W-1:0];
            if (i_wen_period) r_period_sh <= i_wdata[PWM_W-1:0];
            if (w_copy) begin
                r_duty_act   <= r_duty_sh;
                r_period_act <= r_period_sh;
            end
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // A fresh edge beats a simultaneous read-clear.
            r_rise  <= (r_sync2 & ~r_prev) | (r_rise & ~i_stat_clr);
            r_fall  <= (~r_sync2 & r_prev) | (r_fall & ~i_stat_clr);
            r_out   <= w_out;
            r_oe    <= w_oe;
        end
    end

    assign o_ctrl             = r_ctrl;
    assign o_duty             = r_duty_sh;
    assign o_period           = r_period_sh;
    assign o_status[StatPin]  = r_sync2;
    assign o_status[StatRise] = r_rise;
    assign o_status[StatFall] = r_fall;
    assign o_pin_out          = r_out;
    assign o_pin_oe           = r_oe;

endmodule

// File: rtl/i2c_pwm_gpio.sv
// Multi-channel GPIO/PWM peripheral on the I2C register bus: address decode,
// per-channel instances and the combinational read mux.
module i2c_pwm_gpio
    import pwm_gpio_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned PWM_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     addr,
    input  logic           wen,
    input  logic [7:0]     wdata,
    output logic [7:0]     rdata,
    input  logic           rdata_used,
    input  logic [NCH-1:0] pin_in,
    output logic [NCH-1:0] pin_out,
    output logic [NCH-1:0] pin_oe
);

    logic [CtrlW-1:0] w_ctrl   [NCH];
    logic [PWM_W-1:0] w_duty   [NCH];
    logic [PWM_W-1:0] w_period [NCH];
    logic [StatW-1:0] w_status [NCH];

    // Channel index match alone implies addr < 4*NCH, so out-of-range is ignored.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic w_sel;
        assign w_sel = (addr[7:2] == 6'(c));

        pwm_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_wen_ctrl   (wen && w_sel && (addr[1:0] == RegCtrl)),
            .i_wen_duty   (wen && w_sel && (addr[1:0] == RegDuty)),
            .i_wen_period (wen && w_sel && (addr[1:0] == RegPeriod)),
            .i_wdata      (wdata),
            .i_stat_clr   (rdata_used && w_sel && (addr[1:0] == RegStatus)),
            .i_pin        (pin_in[c]),
            .o_ctrl       (w_ctrl[c]),
            .o_duty       (w_duty[c]),
            .o_period     (w_period[c]),
            .o_status     (w_status[c]),
            .o_pin_out    (pin_out[c]),
            .o_pin_oe     (pin_oe[c])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (addr[7:2] == 6'(i)) begin
                unique case (addr[1:0])
                    RegCtrl:   rdata[CtrlW-1:0] = w_ctrl[i];
                    RegDuty:   rdata[PWM_W-1:0] = w_duty[i];
                    RegPeriod: rdata[PWM_W-1:0] = w_period[i];
                    RegStatus: rdata[StatW-1:0] = w_status[i];
                endcase
            end
        end
    end

endmodule
